// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: hazard controls, branch redirect, instruction memory
// port and the IF/ID register outputs presented to decode.
//   master : fetch_stage side (drives imem_addr and the IF/ID outputs)
//   slave  : environment side (hazard unit, EX stage, imem, decode)
interface fetch_stage_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              stall;
  logic              flush;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_data;
  logic [15:0]       if_instr;
  logic [3:0]        if_opcode;
  logic [3:0]        if_rd;
  logic [3:0]        if_rs;
  logic [3:0]        if_imm4;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc_plus1;
  logic              if_valid;
  logic [15:0]       fetch_cnt;

  modport master (
    input  stall, flush, br_taken, br_target, imem_data,
    output imem_addr, if_instr, if_opcode, if_rd, if_rs, if_imm4,
           if_pc, if_pc_plus1, if_valid, fetch_cnt
  );

  modport slave (
    output stall, flush, br_taken, br_target, imem_data,
    input  imem_addr, if_instr, if_opcode, if_rd, if_rs, if_imm4,
           if_pc, if_pc_plus1, if_valid, fetch_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Holds the PC, addresses instruction memory combinationally (same-cycle read)
// and registers the fetched word, its PC, PC+1, a valid flag and a saturating
// count of captured instructions.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active high
//   bus  : fetch_stage_if.master (stall/flush/br_taken/br_target/imem_data in;
//          imem_addr, if_instr and decoded fields, if_pc, if_pc_plus1,
//          if_valid, fetch_cnt out)
module fetch_stage #(
  parameter int unsigned        ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  fetch_stage_if.master  bus
);

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W   = 16;

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_inc;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  if_pc_q;
  logic [ADDR_W-1:0]  if_pc_plus1_q;
  logic               valid_q;
  logic [CNT_W-1:0]   cnt_q;

  // Natural ADDR_W-bit wrap gives the modulo-2^ADDR_W increment.
  assign pc_inc = pc_q + ADDR_W'(1);

  // PC and IF/ID register; priority rst > br_taken > flush > stall > normal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      if_pc_q       <= '0;
      if_pc_plus1_q <= '0;
      valid_q       <= 1'b0;
      cnt_q         <= '0;
    end else if (bus.br_taken) begin
      // Redirect: bubble the wrong-path word; if_pc / if_pc_plus1 hold.
      pc_q    <= bus.br_target;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (bus.flush) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      if (!bus.stall) begin
        pc_q <= pc_inc;
      end
    end else if (!bus.stall) begin
      pc_q          <= pc_inc;
      instr_q       <= bus.imem_data;
      if_pc_q       <= pc_q;
      if_pc_plus1_q <= pc_inc;
      valid_q       <= 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_instr    = instr_q;
  // Decoded fields are plain slices, so a bubble decodes as opcode 0 (NOP).
  assign bus.if_opcode   = instr_q[15:12];
  assign bus.if_rd       = instr_q[11:8];
  assign bus.if_rs       = instr_q[7:4];
  assign bus.if_imm4     = instr_q[3:0];
  assign bus.if_pc       = if_pc_q;
  assign bus.if_pc_plus1 = if_pc_plus1_q;
  assign bus.if_valid    = valid_q;
  assign bus.fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset/saturation sequences and
// randomized hazard traffic against a behavioural model.
module tb_fetch_stage;

  localparam int unsigned ADDR_W = 8;
  localparam int DEPTH = 256;

  logic clk;
  logic rst;
  logic [15:0] mem [DEPTH];

  int n_tests;
  int n_fail;

  // behavioural model state (plain integers)
  int m_pc, m_instr, m_ifpc, m_ifpc1, m_valid, m_cnt;

  fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_data = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        br;
    logic [7:0]  tgt;
    logic [15:0] instr;
    logic [7:0]  ifpc;
    logic [7:0]  ifpc1;
    logic        valid;
    logic [7:0]  addr;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against an expected architectural state.
  task automatic check_all(input string tag, input int instr, input int ifpc, input int ifpc1,
                           input int valid, input int addr, input int cnt);
    check({tag, ".instr"},  32'(bus.if_instr),    32'(instr));
    check({tag, ".opcode"}, 32'(bus.if_opcode),   32'((instr / 4096) % 16));
    check({tag, ".rd"},     32'(bus.if_rd),       32'((instr / 256) % 16));
    check({tag, ".rs"},     32'(bus.if_rs),       32'((instr / 16) % 16));
    check({tag, ".imm4"},   32'(bus.if_imm4),     32'(instr % 16));
    check({tag, ".if_pc"},  32'(bus.if_pc),       32'(ifpc));
    check({tag, ".pc1"},    32'(bus.if_pc_plus1), 32'(ifpc1));
    check({tag, ".valid"},  32'(bus.if_valid),    32'(valid));
    check({tag, ".addr"},   32'(bus.imem_addr),   32'(addr));
    check({tag, ".cnt"},    32'(bus.fetch_cnt),   32'(cnt));
  endtask

  task automatic drive(input logic s, input logic f, input logic b, input logic [7:0] t);
    bus.stall     = s;
    bus.flush     = f;
    bus.br_taken  = b;
    bus.br_target = t;
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_ifpc = 0; m_ifpc1 = 0; m_valid = 0; m_cnt = 0;
  endtask

  // One clock of the model, written from the stage's stated per-edge rules.
  task automatic model_edge(input int s, input int f, input int b, input int t);
    if (b != 0) begin
      m_pc = t; m_instr = 0; m_valid = 0;
    end else if (f != 0) begin
      m_instr = 0; m_valid = 0;
      if (s == 0) m_pc = (m_pc + 1) % DEPTH;
    end else if (s == 0) begin
      m_instr = int'(mem[m_pc]);
      m_ifpc  = m_pc;
      m_ifpc1 = (m_pc + 1) % DEPTH;
      m_valid = 1;
      m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      m_pc    = (m_pc + 1) % DEPTH;
    end
  endtask

  task automatic model_step(input string tag, input logic s, input logic f, input logic b,
                            input logic [7:0] t);
    int tv;
    drive(s, f, b, t);
    tv = int'(t);
    model_edge(int'(s), int'(f), int'(b), tv);
    @(posedge clk);
    #1;
    check_all(tag, m_instr, m_ifpc, m_ifpc1, m_valid, m_pc, m_cnt);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int k = 0; k < DEPTH; k++) mem[k] = 16'h1000 + 16'(k);

    //             s  f  b  tgt    instr     ifpc   ifpc1  v  addr   cnt
    tbl[0]  = '{0, 0, 0, 8'h00, 16'h1000, 8'h00, 8'h01, 1, 8'h01, 16'd1};
    tbl[1]  = '{0, 0, 0, 8'h00, 16'h1001, 8'h01, 8'h02, 1, 8'h02, 16'd2};
    tbl[2]  = '{0, 0, 0, 8'h00, 16'h1002, 8'h02, 8'h03, 1, 8'h03, 16'd3};
    tbl[3]  = '{1, 0, 0, 8'h00, 16'h1002, 8'h02, 8'h03, 1, 8'h03, 16'd3};
    tbl[4]  = '{1, 0, 0, 8'h00, 16'h1002, 8'h02, 8'h03, 1, 8'h03, 16'd3};
    tbl[5]  = '{0, 0, 0, 8'h00, 16'h1003, 8'h03, 8'h04, 1, 8'h04, 16'd4};
    tbl[6]  = '{1, 0, 1, 8'h40, 16'h0000, 8'h03, 8'h04, 0, 8'h40, 16'd4};
    tbl[7]  = '{0, 0, 0, 8'h00, 16'h1040, 8'h40, 8'h41, 1, 8'h41, 16'd5};
    tbl[8]  = '{0, 0, 1, 8'h05, 16'h0000, 8'h40, 8'h41, 0, 8'h05, 16'd5};
    tbl[9]  = '{0, 1, 0, 8'h00, 16'h0000, 8'h40, 8'h41, 0, 8'h06, 16'd5};
    tbl[10] = '{0, 0, 0, 8'h00, 16'h1006, 8'h06, 8'h07, 1, 8'h07, 16'd6};
    tbl[11] = '{1, 1, 0, 8'h00, 16'h0000, 8'h06, 8'h07, 0, 8'h07, 16'd6};
    tbl[12] = '{0, 0, 0, 8'h00, 16'h1007, 8'h07, 8'h08, 1, 8'h08, 16'd7};
    tbl[13] = '{0, 1, 1, 8'hFF, 16'h0000, 8'h07, 8'h08, 0, 8'hFF, 16'd7};
    tbl[14] = '{0, 0, 0, 8'h00, 16'h10FF, 8'hFF, 8'h00, 1, 8'h00, 16'd8};
    tbl[15] = '{0, 0, 0, 8'h00, 16'h1000, 8'h00, 8'h01, 1, 8'h01, 16'd9};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0);

    // directed table
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].stall, tbl[i].flush, tbl[i].br, tbl[i].tgt);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), int'(tbl[i].instr), int'(tbl[i].ifpc),
                int'(tbl[i].ifpc1), int'(tbl[i].valid), int'(tbl[i].addr), int'(tbl[i].cnt));
    end

    // asynchronous reset between edges takes effect immediately
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // saturation: preload the counter to its ceiling, then keep fetching
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 65535;
    #1;
    check("preload_cnt", 32'(bus.fetch_cnt), 32'hFFFF);
    for (int i = 0; i < 3; i++) model_step($sformatf("sat%0d", i), 1'b0, 1'b0, 1'b0, 8'h00);

    // randomized hazard traffic from a fresh reset
    for (int k = 0; k < DEPTH; k++) mem[k] = 16'($urandom);
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      logic s, f, b;
      logic [7:0] t;
      s = ($urandom_range(0, 99) < 25);
      f = ($urandom_range(0, 99) < 15);
      b = ($urandom_range(0, 99) < 10);
      t = 8'($urandom);
      model_step("rand", s, f, b, t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
